// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter: frame-granular round-robin arbiter that shares one MAC
// transmit AXI-Stream input between NUM_SRC requesters. A grant is held until
// the granted frame's last beat. Frames reaching MAX_LEN beats without tlast
// are cut: the MAX_LEN-th beat is forced to tlast and the rest of the source
// frame is drained and discarded.
module tx_frame_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int MAX_LEN = 1518,
    parameter int LEN_W   = 11,
    parameter int ID_W    = 2
) (
    input  logic                   sys_clk,
    input  logic                   sys_rstn,
    input  logic [NUM_SRC-1:0]     src_en,
    input  logic [NUM_SRC*8-1:0]   s_tdata,
    input  logic [NUM_SRC-1:0]     s_tvalid,
    input  logic [NUM_SRC-1:0]     s_tlast,
    output logic [NUM_SRC-1:0]     s_tready,
    output logic [7:0]             m_tdata,
    output logic                   m_tvalid,
    output logic                   m_tlast,
    input  logic                   m_tready,
    output logic [ID_W-1:0]        grant_id,
    output logic                   busy,
    output logic                   frame_trunc
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t            r_state;
    logic [ID_W-1:0]   r_grant;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [LEN_W-1:0]  r_beat_cnt;
    logic              r_trunc;

    logic [NUM_SRC-1:0] w_req;
    logic               w_found;
    logic [ID_W-1:0]    w_win;
    logic               w_src_valid;
    logic               w_src_last;
    logic               w_at_max;
    logic               w_beat;

    assign w_req       = s_tvalid & src_en;
    assign w_src_valid = s_tvalid[r_grant];
    assign w_src_last  = s_tlast[r_grant];
    assign w_at_max    = (r_beat_cnt == LEN_W'(MAX_LEN - 1));
    assign w_beat      = (r_state == ST_DATA) & w_src_valid & m_tready;

    assign grant_id    = r_grant;
    assign busy        = (r_state != ST_IDLE);
    assign frame_trunc = r_trunc;

    // Round-robin winner search: first requester after the last served one.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            if (!w_found && w_req[(int'(r_rr_ptr) + k) % NUM_SRC]) begin
                w_found = 1'b1;
                w_win   = ID_W'((int'(r_rr_ptr) + k) % NUM_SRC);
            end else begin
                w_found = w_found;
            end
        end
    end

    // Datapath mux and per-source ready steering based on state and grant.
    always_comb begin
        s_tready = '0;
        m_tdata  = 8'h00;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        case (r_state)
            ST_DATA: begin
                m_tdata           = s_tdata[8*int'(r_grant) +: 8];
                m_tvalid          = w_src_valid;
                m_tlast           = w_src_last | w_at_max;
                s_tready[r_grant] = m_tready;
            end
            ST_DROP: begin
                s_tready[r_grant] = 1'b1;
            end
            default: begin
                s_tready = '0;
            end
        endcase
    end

    // Arbitration FSM: grant, beat counting, length guard and drain.
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_rr_ptr   <= ID_W'(NUM_SRC - 1);
            r_beat_cnt <= '0;
            r_trunc    <= 1'b0;
        end else begin
            r_trunc <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant    <= w_win;
                        r_beat_cnt <= '0;
                        r_state    <= ST_DATA;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + LEN_W'(1);
                        if (w_src_last) begin
                            r_rr_ptr <= r_grant;
                            r_state  <= ST_IDLE;
                        end else if (w_at_max) begin
                            // Runaway frame: downstream already saw a forced tlast.
                            r_rr_ptr <= r_grant;
                            r_trunc  <= 1'b1;
                            r_state  <= ST_DROP;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end else begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DROP: begin
                    if (s_tvalid[r_grant] && s_tlast[r_grant]) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_DROP;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
